// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcodes, instruction field positions and the
// fetch-unit state encoding.
package lc2k_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  localparam int unsigned OPCODE_LSB = 22;
  localparam int unsigned REG_A_LSB  = 19;
  localparam int unsigned REG_B_LSB  = 16;
  localparam int unsigned DEST_LSB   = 0;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned OFFSET_W   = 16;
  localparam int unsigned FIELD_W    = 3;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    HALTED = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] sign_ext_offset(input logic [OFFSET_W-1:0] off);
    return {{(XLEN-OFFSET_W){off[OFFSET_W-1]}}, off};
  endfunction

endpackage

// File: rtl/lc2k_field_decode.sv
// Purely combinational split of an LC2K instruction word into its fields,
// with the 16-bit offset sign-extended to the full datapath width.
module lc2k_field_decode
  import lc2k_pkg::*;
(
  input  logic [XLEN-1:0]    ir,
  output logic [FIELD_W-1:0] opcode,
  output logic [FIELD_W-1:0] reg_a,
  output logic [FIELD_W-1:0] reg_b,
  output logic [FIELD_W-1:0] dest_reg,
  output logic [XLEN-1:0]    offset_ext
);

  // Bits above the opcode are architecturally unused in LC2K.
  logic unused_hi_bits;
  assign unused_hi_bits = ^ir[XLEN-1:OPCODE_LSB+FIELD_W];

  assign opcode     = ir[OPCODE_LSB +: FIELD_W];
  assign reg_a      = ir[REG_A_LSB  +: FIELD_W];
  assign reg_b      = ir[REG_B_LSB  +: FIELD_W];
  assign dest_reg   = ir[DEST_LSB   +: FIELD_W];
  assign offset_ext = sign_ext_offset(ir[OFFSET_LSB +: OFFSET_W]);

endmodule

// File: rtl/lc2k_fetch_unit.sv
// LC2K multi-cycle fetch/decode stage: owns PC, IR and the retired-instruction
// counter, fetches over a req/ack handshake and selects the next PC on retire.
module lc2k_fetch_unit
  import lc2k_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,

  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,

  output logic             instr_valid,
  output logic [31:0]      pc_current,
  output logic [2:0]       opcode,
  output logic [2:0]       reg_a,
  output logic [2:0]       reg_b,
  output logic [2:0]       dest_reg,
  output logic [31:0]      offset_ext,

  input  logic             exec_done,
  input  logic             branch_taken,
  input  logic             jalr_taken,
  input  logic [31:0]      jalr_target,

  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      pc_seq;
  logic [31:0]      pc_branch;

  lc2k_field_decode u_field_decode (
    .ir         (ir_q),
    .opcode     (opcode),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .dest_reg   (dest_reg),
    .offset_ext (offset_ext)
  );

  // All PC arithmetic wraps modulo 2^32 by construction of the 32-bit sums.
  assign pc_seq    = pc_q + 32'd1;
  assign pc_branch = pc_seq + offset_ext;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end

      DECODE: begin
        if (exec_done) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (opcode == OP_HALT) begin
            pc_d    = pc_seq;
            state_d = HALTED;
          end else begin
            state_d = FETCH;
            if (jalr_taken)        pc_d = jalr_target;
            else if (branch_taken) pc_d = pc_branch;
            else                   pc_d = pc_seq;
          end
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      // NOTE: IR is cleared so the decode outputs read as zero out of reset;
      // it is a single register, not a memory, so the reset costs nothing.
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == DECODE);
  assign pc_current  = pc_q;
  assign halted      = (state_q == HALTED);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_lc2k_fetch_unit.sv
// Directed bench for lc2k_fetch_unit: reset, field extraction, branch/jalr
// PC selection, ack stalls, halt, mid-decode reset and PC wrap-around.
module tb_lc2k_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        imem_req, imem_ack, instr_valid, halted;
  logic [31:0] imem_addr, imem_rdata, pc_current, offset_ext, jalr_target;
  logic [2:0]  opcode, reg_a, reg_b, dest_reg;
  logic        exec_done, branch_taken, jalr_taken;
  logic [31:0] instr_count;

  logic        w_req, w_ack, w_valid, w_halted, w_exec;
  logic [31:0] w_addr, w_rdata, w_pc, w_off;
  logic [2:0]  w_op, w_ra, w_rb, w_dst;
  logic [31:0] w_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lc2k_fetch_unit #(.RESET_PC(32'd0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .pc_current(pc_current), .opcode(opcode), .reg_a(reg_a),
    .reg_b(reg_b), .dest_reg(dest_reg), .offset_ext(offset_ext),
    .exec_done(exec_done), .branch_taken(branch_taken), .jalr_taken(jalr_taken),
    .jalr_target(jalr_target), .halted(halted), .instr_count(instr_count)
  );

  lc2k_fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .CNT_W(32)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .pc_current(w_pc), .opcode(w_op), .reg_a(w_ra),
    .reg_b(w_rb), .dest_reg(w_dst), .offset_ext(w_off),
    .exec_done(w_exec), .branch_taken(1'b0), .jalr_taken(1'b0),
    .jalr_target(32'd0), .halted(w_halted), .instr_count(w_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  task automatic retire(input logic br, input logic jr, input logic [31:0] tgt);
    exec_done    = 1'b1;
    branch_taken = br;
    jalr_taken   = jr;
    jalr_target  = tgt;
    step();
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    jalr_taken   = 1'b0;
    jalr_target  = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    imem_ack = 1'b0; imem_rdata = 32'd0;
    exec_done = 1'b0; branch_taken = 1'b0; jalr_taken = 1'b0; jalr_target = 32'd0;
    w_ack = 1'b0; w_rdata = 32'd0; w_exec = 1'b0;

    // Reset sequence
    do_reset();
    check("rst_req",    {31'd0, imem_req},    32'd1);
    check("rst_addr",   imem_addr,            32'd0);
    check("rst_valid",  {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted},      32'd0);
    check("rst_count",  instr_count,          32'd0);
    check("rst_opcode", {29'd0, opcode},      32'd0);
    check("rst_offset", offset_ext,           32'd0);

    // Field extraction: lw 0 1 -2
    fetch(32'h0081_FFFE);
    check("lw_valid",  {31'd0, instr_valid}, 32'd1);
    check("lw_req",    {31'd0, imem_req},    32'd0);
    check("lw_opcode", {29'd0, opcode},      32'd2);
    check("lw_reg_a",  {29'd0, reg_a},       32'd0);
    check("lw_reg_b",  {29'd0, reg_b},       32'd1);
    check("lw_dest",   {29'd0, dest_reg},    32'd6);
    check("lw_offset", offset_ext,           32'hFFFF_FFFE);
    check("lw_pc",     pc_current,           32'd0);
    step();
    check("lw_hold_offset", offset_ext, 32'hFFFF_FFFE);
    check("lw_hold_valid",  {31'd0, instr_valid}, 32'd1);
    check("lw_hold_count",  instr_count, 32'd0);
    retire(1'b0, 1'b0, 32'd0);
    check("seq_addr",  imem_addr,         32'd1);
    check("seq_req",   {31'd0, imem_req}, 32'd1);
    check("seq_count", instr_count,       32'd1);

    // Jump to pc 5 via jalr on a noop word
    fetch(32'h01C0_0000);
    retire(1'b0, 1'b1, 32'd5);
    check("jalr5_addr", imem_addr, 32'd5);

    // Branch target: beq 0 0 -3 at pc 5 -> 5 + 1 - 3 = 3
    fetch(32'h0100_FFFD);
    check("beq_opcode", {29'd0, opcode}, 32'd4);
    check("beq_offset", offset_ext,      32'hFFFF_FFFD);
    retire(1'b1, 1'b0, 32'd0);
    check("beq_addr",  imem_addr,   32'd3);
    check("beq_count", instr_count, 32'd3);

    // Ack held off 4 cycles; a stray exec_done during FETCH is ignored
    for (int i = 0; i < 4; i++) begin
      exec_done = (i == 1);
      step();
      check("stall_req",   {31'd0, imem_req},    32'd1);
      check("stall_addr",  imem_addr,            32'd3);
      check("stall_valid", {31'd0, instr_valid}, 32'd0);
      check("stall_count", instr_count,          32'd3);
    end
    exec_done = 1'b0;
    fetch(32'h01C0_0000);
    check("noop_opcode", {29'd0, opcode}, 32'd7);
    check("noop_pc",     pc_current,      32'd3);

    // Jalr beats branch when both are asserted
    retire(1'b1, 1'b1, 32'h40);
    check("jalr_prio_addr", imem_addr,   32'h40);
    check("jalr_prio_count", instr_count, 32'd4);

    // Get to pc 7, then retire halt
    fetch(32'h0000_0000);
    retire(1'b0, 1'b1, 32'd7);
    check("pc7_addr", imem_addr, 32'd7);
    fetch(32'h0180_0000);
    check("halt_opcode", {29'd0, opcode}, 32'd6);
    retire(1'b0, 1'b0, 32'd0);
    check("halt_flag",  {31'd0, halted},      32'd1);
    check("halt_pc",    pc_current,           32'd8);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_count", instr_count,          32'd6);
    for (int i = 0; i < 20; i++) begin
      exec_done = i[0];
      imem_ack  = ~i[0];
      step();
      check("halted_req",   {31'd0, imem_req}, 32'd0);
      check("halted_flag",  {31'd0, halted},   32'd1);
      check("halted_count", instr_count,       32'd6);
      check("halted_pc",    pc_current,        32'd8);
    end
    exec_done = 1'b0;
    imem_ack  = 1'b0;

    // Reset during DECODE with exec_done high abandons the instruction
    do_reset();
    check("rst2_addr", imem_addr, 32'd0);
    fetch(32'h0081_FFFE);
    check("rst2_valid", {31'd0, instr_valid}, 32'd1);
    reset     = 1'b1;
    exec_done = 1'b1;
    step();
    reset     = 1'b0;
    exec_done = 1'b0;
    check("middec_count",  instr_count,          32'd0);
    check("middec_addr",   imem_addr,            32'd0);
    check("middec_req",    {31'd0, imem_req},    32'd1);
    check("middec_valid",  {31'd0, instr_valid}, 32'd0);
    check("middec_halted", {31'd0, halted},      32'd0);
    check("middec_opcode", {29'd0, opcode},      32'd0);
    fetch(32'h01C0_0000);
    retire(1'b0, 1'b0, 32'd0);
    check("after_rst_count", instr_count, 32'd1);
    check("after_rst_addr",  imem_addr,   32'd1);

    // PC wrap-around on the second instance
    check("wrap_start_addr", w_addr,         32'hFFFF_FFFF);
    check("wrap_start_req",  {31'd0, w_req}, 32'd1);
    w_ack   = 1'b1;
    w_rdata = 32'h01C0_0000;
    step();
    w_ack   = 1'b0;
    w_rdata = 32'd0;
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    w_exec = 1'b1;
    step();
    w_exec = 1'b0;
    check("wrap_addr",  w_addr,  32'd0);
    check("wrap_count", w_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lc2k_fetch_unit.md
# lc2k_fetch_unit

Multi-cycle instruction fetch and decode stage for the LC2K core. It sits directly upstream of the control decoder. It owns the program counter, fetches one 32-bit word from instruction memory over a req/ack handshake, and splits the word into LC2K fields with the offset sign-extended. It presents the decoded instruction until execute signals completion, then selects the next PC (sequential, beq target, or jalr target), or stops permanently on halt.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  32  word address of the fetch; equals `pc_current`.
- `imem_ack`  in  1  fetch accepted; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  decoded fields below are valid.
- `pc_current`  out  32  PC of the presented instruction.
- `opcode`  out  3  `instr[24:22]`.
- `reg_a`  out  3  `instr[21:19]`.
- `reg_b`  out  3  `instr[18:16]`.
- `dest_reg`  out  3  `instr[2:0]`.
- `offset_ext`  out  32  `instr[15:0]` sign-extended to 32 bits.
- `exec_done`  in  1  execute has retired the presented instruction.
- `branch_taken`  in  1  beq condition true; sampled with `exec_done`.
- `jalr_taken`  in  1  jalr executing; sampled with `exec_done`.
- `jalr_target`  in  32  regA value for jalr; sampled with `exec_done`.
- `halted`  out  1  halt retired; the core is stopped.
- `instr_count`  out  `CNT_W`  number of retired instructions.

## Operation
- FSM states: FETCH, DECODE, HALTED.
- Reset: state = FETCH, pc = `RESET_PC`, IR = 0, `instr_count` = 0.
  - Output reset values: `instr_valid` = 0, `halted` = 0, all decode fields = 0.
  - `imem_req` is 1 in the first cycle after reset deasserts.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = pc.
  - On `imem_ack`: IR <= `imem_rdata`, then go to DECODE.
- DECODE:
  - `instr_valid` = 1; all fields are combinational from IR.
  - On `exec_done`, `instr_count` increments (wraps modulo 2^`CNT_W`).
  - If opcode = 3'b110 (halt): pc <= pc+1, then go to HALTED.
  - Otherwise go to FETCH and update pc:
    - `jalr_taken`: pc <= `jalr_target`.
    - else `branch_taken`: pc <= pc + 1 + `offset_ext`.
    - else: pc <= pc + 1.
  - If `jalr_taken` and `branch_taken` are both high, jalr wins.
- HALTED:
  - Terminal until reset.
  - `halted` = 1, `imem_req` = 0, `instr_valid` = 0.
  - `exec_done` is ignored.
- All PC arithmetic is 32-bit and wraps modulo 2^32; no overflow flag.
- `imem_ack` outside FETCH is ignored. `exec_done` outside DECODE is ignored.
- Reset mid-fetch or mid-decode abandons the instruction; the counter is not incremented. Instruction memory shares `reset`, so no stale ack arrives after reset.

## Timing
- Fetch latency: with a same-cycle ack, `instr_valid` rises 1 cycle after the FETCH cycle.
- Minimum throughput is 2 cycles per instruction (FETCH + DECODE, with `exec_done` in the first DECODE cycle).
- `imem_addr` is stable from `imem_req` rise until `imem_ack`.
- Decoded fields and `pc_current` are stable for the whole time `instr_valid` is high.
- The new pc is visible on `imem_addr` in the cycle after `exec_done`.
- `halted` rises in the cycle after a halt's `exec_done` and stays high until reset.

## Structure
- Shared package `lc2k_pkg` holds:
  - opcode constants (ADD=0, NOR=1, LW=2, SW=3, BEQ=4, JALR=5, HALT=6, NOOP=7);
  - field bit positions;
  - the state enum {FETCH, DECODE, HALTED}.
- One natural sub-module, `lc2k_field_decode`: purely combinational IR to opcode/reg_a/reg_b/dest_reg/offset_ext. The top level keeps the FSM, PC, IR and counter.

## Test plan
- Reset sequence:
  - Stimulus: reset 2 cycles with `RESET_PC` = 0.
  - Required: `imem_req` = 1 and `imem_addr` = 0 in the first cycle after release; `instr_valid` = 0, `halted` = 0, `instr_count` = 0.
- Field extraction:
  - Stimulus: fetch word 0x0081FFFE (lw 0 1 -2).
  - Required: opcode = 2, reg_a = 0, reg_b = 1, offset_ext = 0xFFFFFFFE.
  - Stimulus: `exec_done` with no taken flags.
  - Required: next `imem_addr` = 1.
- Branch target:
  - Stimulus: at pc = 5, beq with offset = -3, then `exec_done` with `branch_taken` = 1.
  - Required: next `imem_addr` = 3.
  - Stimulus: ack held off 4 cycles.
  - Required: `imem_req` and address stay stable for those 4 cycles.
- Jalr priority:
  - Stimulus: `jalr_taken` = 1, `branch_taken` = 1, `jalr_target` = 0x40 together with `exec_done`.
  - Required: next `imem_addr` = 0x40.
- Halt:
  - Stimulus: at pc = 7, opcode 6 retired via `exec_done`.
  - Required: `halted` = 1 the next cycle and pc = 8. After that, `imem_req` stays 0 for 20 cycles, `instr_count` is unchanged, and further `exec_done` pulses are ignored.
- Reset mid-operation and wrap-around:
  - Stimulus: assert reset during DECODE.
  - Required: `instr_count` is not incremented and the fetch restarts at `RESET_PC`.
  - Stimulus: `RESET_PC` = 0xFFFFFFFF, one sequential retire.
  - Required: next `imem_addr` = 0.
